// File: rtl/brush_writer.sv
// brush_writer: write-side engine for the pixel colour store.
// Turns a cursor paint request into a row-major walk over a (2R+1)x(2R+1)
// square brush, or a full-canvas clear, presenting one registered write per
// cycle on (wx, wy, newColor, brush). Both operations share one walker: an
// operation is a signed base corner, an x/y span and a colour.
module brush_writer #(
    parameter int         WIDTH       = 8,
    parameter int         HEIGHT      = 8,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       paint_req,
    input  logic       clear_req,
    input  logic [7:0] cx,
    input  logic [7:0] cy,
    input  logic [2:0] color,
    input  logic [1:0] radius,
    output logic [7:0] wx,
    output logic [7:0] wy,
    output logic [2:0] newColor,
    output logic       brush,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAMP = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // Canvas bounds in the walker's 10-bit signed coordinate space.
    localparam logic signed [9:0] WIDTH_S  = 10'(WIDTH);
    localparam logic signed [9:0] HEIGHT_S = 10'(HEIGHT);

    // Sequential state.
    state_e            state_q;
    logic signed [9:0] base_x_q;
    logic signed [9:0] base_y_q;
    logic [7:0]        span_x_q;
    logic [7:0]        span_y_q;
    logic [7:0]        off_x_q;
    logic [7:0]        off_y_q;
    logic [2:0]        color_q;
    logic              fin_q;      // outputs currently show the last candidate
    logic [7:0]        wx_q;
    logic [7:0]        wy_q;
    logic [2:0]        new_color_q;
    logic              brush_q;
    logic              busy_q;
    logic              done_q;

    // Operation descriptor for a request sampled this cycle.
    logic signed [9:0] req_base_x;
    logic signed [9:0] req_base_y;
    logic [7:0]        req_span_x;
    logic [7:0]        req_span_y;
    logic [2:0]        req_color;

    // Current candidate and the walker's next position.
    logic signed [9:0] cur_base_x;
    logic signed [9:0] cur_base_y;
    logic [7:0]        cur_span_x;
    logic [7:0]        cur_span_y;
    logic [7:0]        cur_off_x;
    logic [7:0]        cur_off_y;
    logic [2:0]        cur_color;
    logic signed [9:0] cand_x;
    logic signed [9:0] cand_y;
    logic              cand_in;
    logic              wrap_x;
    logic [7:0]        nxt_off_x;
    logic [7:0]        nxt_off_y;
    logic              is_last;

    // Decode an incoming request into base corner, spans and colour; clear wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_base_x = '0;
        req_base_y = '0;
        req_span_x = '0;
        req_span_y = '0;
        req_color  = '0;
        if (clear_req) begin
            req_span_x = 8'(WIDTH - 1);
            req_span_y = 8'(HEIGHT - 1);
            req_color  = CLEAR_COLOR;
        end else begin
            // Widening to 10-bit signed keeps cx-R from wrapping near column 0.
            req_base_x = $signed({2'b00, cx}) - $signed({8'b0, radius});
            req_base_y = $signed({2'b00, cy}) - $signed({8'b0, radius});
            req_span_x = {5'b0, radius, 1'b0};
            req_span_y = {5'b0, radius, 1'b0};
            req_color  = color;
        end
    end

    // Select the candidate being emitted this cycle and advance the walker.
    always_comb begin
        cur_base_x = base_x_q;
        cur_base_y = base_y_q;
        cur_span_x = span_x_q;
        cur_span_y = span_y_q;
        cur_off_x  = off_x_q;
        cur_off_y  = off_y_q;
        cur_color  = color_q;
        if (state_q == IDLE) begin
            // The accepting edge already emits the first candidate, so the
            // walk starts from the freshly decoded request at offset (0,0).
            cur_base_x = req_base_x;
            cur_base_y = req_base_y;
            cur_span_x = req_span_x;
            cur_span_y = req_span_y;
            cur_off_x  = '0;
            cur_off_y  = '0;
            cur_color  = req_color;
        end
        cand_x    = cur_base_x + $signed({2'b00, cur_off_x});
        cand_y    = cur_base_y + $signed({2'b00, cur_off_y});
        cand_in   = (cand_x >= 10'sd0) && (cand_x < WIDTH_S) &&
                    (cand_y >= 10'sd0) && (cand_y < HEIGHT_S);
        wrap_x    = (cur_off_x == cur_span_x);
        nxt_off_x = wrap_x ? 8'd0 : cur_off_x + 8'd1;
        nxt_off_y = wrap_x ? cur_off_y + 8'd1 : cur_off_y;
        is_last   = wrap_x && (cur_off_y == cur_span_y);
    end

    // Control FSM with registered write-port outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Datapath registers are reset too so the write port reads 0 after reset.
            state_q     <= IDLE;
            base_x_q    <= '0;
            base_y_q    <= '0;
            span_x_q    <= '0;
            span_y_q    <= '0;
            off_x_q     <= '0;
            off_y_q     <= '0;
            color_q     <= '0;
            fin_q       <= 1'b0;
            wx_q        <= '0;
            wy_q        <= '0;
            new_color_q <= '0;
            brush_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    brush_q <= 1'b0;
                    if (clear_req || paint_req) begin
                        state_q  <= clear_req ? CLEAR : STAMP;
                        base_x_q <= req_base_x;
                        base_y_q <= req_base_y;
                        span_x_q <= req_span_x;
                        span_y_q <= req_span_y;
                        color_q  <= req_color;
                        off_x_q  <= nxt_off_x;
                        off_y_q  <= nxt_off_y;
                        fin_q    <= is_last;
                        busy_q   <= 1'b1;
                        brush_q  <= cand_in;
                        if (cand_in) begin
                            wx_q        <= cand_x[7:0];
                            wy_q        <= cand_y[7:0];
                            new_color_q <= cur_color;
                        end
                    end
                end
                STAMP, CLEAR: begin
                    if (fin_q) begin
                        // Last candidate has been presented: retire the operation.
                        state_q <= IDLE;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        brush_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        off_x_q <= nxt_off_x;
                        off_y_q <= nxt_off_y;
                        fin_q   <= is_last;
                        brush_q <= cand_in;
                        if (cand_in) begin
                            wx_q        <= cand_x[7:0];
                            wy_q        <= cand_y[7:0];
                            new_color_q <= cur_color;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    fin_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    brush_q <= 1'b0;
                end
            endcase
        end
    end

    assign wx       = wx_q;
    assign wy       = wy_q;
    assign newColor = new_color_q;
    assign brush    = brush_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_brush_writer.sv
// Testbench for brush_writer: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_brush_writer;

    localparam logic [2:0] CLR = 3'b000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       paint_req;
    logic       clear_req;
    logic [7:0] cx;
    logic [7:0] cy;
    logic [2:0] color;
    logic [1:0] radius;
    logic [7:0] wx;
    logic [7:0] wy;
    logic [2:0] newColor;
    logic       brush;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    brush_writer #(.WIDTH(8), .HEIGHT(8), .CLEAR_COLOR(CLR)) dut (
        .clk(clk), .reset_n(reset_n), .paint_req(paint_req), .clear_req(clear_req),
        .cx(cx), .cy(cy), .color(color), .radius(radius),
        .wx(wx), .wy(wy), .newColor(newColor), .brush(brush), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       brush;
        logic       busy;
        logic       done;
        logic [7:0] wx;
        logic [7:0] wy;
        logic [2:0] col;
    } exp_t;

    exp_t       pend[$];            // expected outputs for future cycles
    exp_t       cur;                // expectation for the current cycle
    bit         cur_valid = 1'b0;
    logic [7:0] m_wx = '0;
    logic [7:0] m_wy = '0;
    logic [2:0] m_col = '0;
    logic [2:0] model_canvas[8][8];
    logic [2:0] dut_canvas[8][8];

    initial begin
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                model_canvas[y][x] = '0;
                dut_canvas[y][x]   = '0;
            end
    end

    // Expand an accepted request into its list of per-cycle outputs.
    task automatic build_op();
        logic [7:0] hx = m_wx;
        logic [7:0] hy = m_wy;
        logic [2:0] hc = m_col;
        exp_t e;
        if (clear_req) begin
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++) begin
                    hx = 8'(x); hy = 8'(y); hc = CLR;
                    e.brush = 1'b1; e.busy = 1'b1; e.done = 1'b0;
                    e.wx = hx; e.wy = hy; e.col = hc;
                    pend.push_back(e);
                end
        end else begin
            int r  = int'(radius);
            int x0 = int'(cx);
            int y0 = int'(cy);
            for (int y = y0 - r; y <= y0 + r; y++)
                for (int x = x0 - r; x <= x0 + r; x++) begin
                    e.brush = 1'b0;
                    if (x >= 0 && x < 8 && y >= 0 && y < 8) begin
                        hx = 8'(x); hy = 8'(y); hc = color;
                        e.brush = 1'b1;
                    end
                    e.busy = 1'b1; e.done = 1'b0;
                    e.wx = hx; e.wy = hy; e.col = hc;
                    pend.push_back(e);
                end
        end
        e.brush = 1'b0; e.busy = 1'b0; e.done = 1'b1;
        e.wx = hx; e.wy = hy; e.col = hc;
        pend.push_back(e);
        m_wx = hx; m_wy = hy; m_col = hc;
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            pend.delete();
            m_wx = '0; m_wy = '0; m_col = '0;
            cur = '0;
            cur_valid = 1'b1;
        end else begin
            if (pend.size() == 0 && (clear_req || paint_req)) build_op();
            if (pend.size() != 0) begin
                cur = pend.pop_front();
            end else begin
                cur.brush = 1'b0; cur.busy = 1'b0; cur.done = 1'b0;
                cur.wx = m_wx; cur.wy = m_wy; cur.col = m_col;
            end
            if (cur.brush) model_canvas[cur.wy[2:0]][cur.wx[2:0]] = cur.col;
        end
    end

    // ---------------- compare + monitor ----------------
    typedef struct {
        int         x;
        int         y;
        logic [2:0] c;
    } wr_t;

    wr_t wlog[$];
    int  busy_cycles = 0;
    int  done_count  = 0;

    always @(negedge clk) begin
        if (cur_valid) begin
            check("brush", 32'(brush), 32'(cur.brush));
            check("busy", 32'(busy), 32'(cur.busy));
            check("done", 32'(done), 32'(cur.done));
            check("wx", 32'(wx), 32'(cur.wx));
            check("wy", 32'(wy), 32'(cur.wy));
            check("newColor", 32'(newColor), 32'(cur.col));
        end
        if (brush === 1'b1) begin
            wlog.push_back('{int'(wx), int'(wy), newColor});
            if (wx < 8 && wy < 8) dut_canvas[wy[2:0]][wx[2:0]] = newColor;
        end
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) done_count++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Hold the request(s) for exactly one sampling edge.
    task automatic start_op(input bit p, input bit c, input int x, input int y,
                            input logic [2:0] col, input logic [1:0] r);
        cx = 8'(x); cy = 8'(y); color = col; radius = r;
        paint_req = p; clear_req = c;
        tick();
        paint_req = 1'b0; clear_req = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int start = done_count;
        int n = 0;
        while (done_count == start && n < bound) begin
            tick();
            n++;
        end
        check(name, 32'(done_count - start), 32'd1);
    endtask

    int maxc;
    int changed;
    int nonzero;
    int dc;
    int n;
    logic [2:0] snap[8][8];

    initial begin
        reset_n = 1'b0; paint_req = 1'b1; clear_req = 1'b0;
        cx = 8'd3; cy = 8'd3; color = 3'd7; radius = 2'd1;

        // Reset held with paint_req high: everything idle.
        tick(); tick();
        check("rst_brush", 32'(brush), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wx", 32'(wx), 32'd0);
        check("rst_wy", 32'(wy), 32'd0);
        reset_n = 1'b1; paint_req = 1'b0;
        repeat (3) tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done_count), 32'd0);

        // Single-pixel stamp.
        wlog.delete();
        start_op(1'b1, 1'b0, 3, 5, 3'b101, 2'd0);
        wait_done(20, "pix_done");
        check("pix_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) begin
            check("pix_x", 32'(wlog[0].x), 32'd3);
            check("pix_y", 32'(wlog[0].y), 32'd5);
            check("pix_c", 32'(wlog[0].c), 32'd5);
        end

        // Interior 3x3 stamp.
        snap = dut_canvas;
        wlog.delete();
        start_op(1'b1, 1'b0, 4, 4, 3'b110, 2'd1);
        wait_done(40, "i3_done");
        check("i3_count", 32'(wlog.size()), 32'd9);
        if (wlog.size() == 9) begin
            check("i3_first", 32'((wlog[0].y << 8) | wlog[0].x), 32'h0303);
            check("i3_second", 32'((wlog[1].y << 8) | wlog[1].x), 32'h0304);
            check("i3_fourth", 32'((wlog[3].y << 8) | wlog[3].x), 32'h0403);
            check("i3_last", 32'((wlog[8].y << 8) | wlog[8].x), 32'h0505);
        end
        changed = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (dut_canvas[y][x] !== snap[y][x]) changed++;
        check("i3_changed", 32'(changed), 32'd9);

        // Corner clip.
        busy_cycles = 0;
        wlog.delete();
        start_op(1'b1, 1'b0, 0, 0, 3'b011, 2'd2);
        wait_done(60, "corner_done");
        check("corner_busy", 32'(busy_cycles), 32'd25);
        check("corner_count", 32'(wlog.size()), 32'd9);
        maxc = 0;
        foreach (wlog[i]) begin
            if (wlog[i].x > maxc) maxc = wlog[i].x;
            if (wlog[i].y > maxc) maxc = wlog[i].y;
        end
        check("corner_max", 32'(maxc), 32'd2);

        // Fully off-canvas cursor: same cycle count, no writes.
        busy_cycles = 0;
        wlog.delete();
        start_op(1'b1, 1'b0, 200, 3, 3'b111, 2'd1);
        wait_done(40, "off_done");
        check("off_busy", 32'(busy_cycles), 32'd9);
        check("off_count", 32'(wlog.size()), 32'd0);

        // Clear has priority over paint; paint mid-clear is ignored.
        busy_cycles = 0;
        wlog.delete();
        start_op(1'b1, 1'b1, 2, 2, 3'b111, 2'd1);
        repeat (10) tick();
        paint_req = 1'b1;
        tick();
        paint_req = 1'b0;
        wait_done(100, "clr_done");
        check("clr_busy", 32'(busy_cycles), 32'd64);
        check("clr_count", 32'(wlog.size()), 32'd64);
        if (wlog.size() == 64) begin
            check("clr_idx9", 32'((wlog[9].y << 8) | wlog[9].x), 32'h0101);
            check("clr_last", 32'((wlog[63].y << 8) | wlog[63].x), 32'h0707);
        end
        nonzero = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (dut_canvas[y][x] !== CLR) nonzero++;
        check("clr_nonzero", 32'(nonzero), 32'd0);
        repeat (3) tick();
        check("clr_no_restamp", 32'(busy), 32'd0);

        // Abort a clear with reset during write 20.
        wlog.delete();
        dc = done_count;
        start_op(1'b0, 1'b1, 0, 0, 3'b000, 2'd0);
        n = 0;
        while (wlog.size() < 20 && n < 100) begin
            tick();
            n++;
        end
        check("abort_reached20", 32'(wlog.size()), 32'd20);
        reset_n = 1'b0;
        tick();
        check("abort_brush", 32'(brush), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        check("abort_no_done", 32'(done_count - dc), 32'd0);
        check("abort_writes", 32'(wlog.size()), 32'd20);

        wlog.delete();
        start_op(1'b1, 1'b0, 3, 5, 3'b101, 2'd0);
        wait_done(20, "pix2_done");
        check("pix2_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1)
            check("pix2_xyc", 32'((wlog[0].c << 16) | (wlog[0].y << 8) | wlog[0].x), 32'h050503);

        // Randomized traffic, including back-to-back requests and rare resets.
        for (int i = 0; i < 3000; i++) begin
            paint_req = ($urandom % 3 == 0);
            clear_req = ($urandom % 60 == 0);
            cx = ($urandom % 5 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
            cy = ($urandom % 5 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
            color = 3'($urandom);
            radius = 2'($urandom);
            reset_n = ($urandom % 800 != 0);
            tick();
        end

        // Drain and compare the painted canvas with the model's.
        paint_req = 1'b0; clear_req = 1'b0; reset_n = 1'b1;
        n = 0;
        while ((pend.size() != 0 || busy !== 1'b0) && n < 200) begin
            tick();
            n++;
        end
        check("drain_idle", 32'(busy), 32'd0);
        repeat (2) tick();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                check($sformatf("canvas_%0d_%0d", x, y), 32'(dut_canvas[y][x]), 32'(model_canvas[y][x]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
